// File: rtl/systolic_skew_feeder_if.sv
// Vector bus between the operand source, the skew feeder and the systolic array edges.
interface systolic_skew_feeder_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ARRAY_SIZE = 16
);
   logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_a;
   logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_b;
   logic                             in_valid;
   logic                             in_last;
   logic                             in_ready;
   logic [ARRAY_SIZE*DATA_WIDTH-1:0] left_out;
   logic [ARRAY_SIZE*DATA_WIDTH-1:0] top_out;
   logic                             busy;
   logic                             done;

   modport master (
      output in_a, in_b, in_valid, in_last,
      input  in_ready, left_out, top_out, busy, done
   );

   modport slave (
      input  in_a, in_b, in_valid, in_last,
      output in_ready, left_out, top_out, busy, done
   );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder for an NxN systolic array: lane k is delayed 1+k cycles, then flush and done.
// Optional accepted-vector counter enabled by defining SKEW_FEEDER_STATS_EN.
module systolic_skew_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int ARRAY_SIZE = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   systolic_skew_feeder_if.slave bus
`ifdef SKEW_FEEDER_STATS_EN
   ,
   output logic [15:0]           vec_count
`endif
);
   localparam int N          = ARRAY_SIZE;
   localparam int DW         = DATA_WIDTH;
   localparam int VW         = N * DW;
   localparam int CNT_W      = $clog2(2 * N);
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(2 * N - 2);

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
   logic             ready_int, busy_int, done_int;
   logic             accept;
   logic [VW-1:0]    slot_a, slot_b;
   logic [VW-1:0]    left_vec, top_vec;

   assign ready_int = !rst && (state_reg == IDLE || state_reg == STREAM);
   assign accept    = bus.in_valid && ready_int;

   // Bubbles zero both operands together so A/B stay aligned inside the array.
   assign slot_a = accept ? bus.in_a : '0;
   assign slot_b = accept ? bus.in_b : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         flush_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         flush_cnt_reg <= flush_cnt_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      flush_cnt_next = flush_cnt_reg;
      busy_int       = 1'b0;
      done_int       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (bus.in_last) begin
                  state_next     = FLUSH;
                  flush_cnt_next = FLUSH_LOAD;
               end else begin
                  state_next = STREAM;
               end
            end
         end
         STREAM: begin
            busy_int = 1'b1;
            if (accept && bus.in_last) begin
               state_next     = FLUSH;
               flush_cnt_next = FLUSH_LOAD;
            end
         end
         FLUSH: begin
            // Loaded with 2N-2 so the state spans 2N-1 cycles including the zero count.
            busy_int = 1'b1;
            if (flush_cnt_reg == '0) begin
               state_next = DONE;
            end else begin
               flush_cnt_next = flush_cnt_reg - 1'b1;
            end
         end
         DONE: begin
            done_int   = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         logic [DW-1:0] a_sr_reg [0:gi];
         logic [DW-1:0] b_sr_reg [0:gi];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int j = 0; j <= gi; j++) begin
                  a_sr_reg[j] <= '0;
                  b_sr_reg[j] <= '0;
               end
            end else begin
               a_sr_reg[0] <= slot_a[gi*DW +: DW];
               b_sr_reg[0] <= slot_b[gi*DW +: DW];
               for (int j = 1; j <= gi; j++) begin
                  a_sr_reg[j] <= a_sr_reg[j-1];
                  b_sr_reg[j] <= b_sr_reg[j-1];
               end
            end
         end

         assign left_vec[gi*DW +: DW] = a_sr_reg[gi];
         assign top_vec[gi*DW +: DW]  = b_sr_reg[gi];
      end
   endgenerate

`ifdef SKEW_FEEDER_STATS_EN
   logic [15:0] vec_count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         vec_count_reg <= '0;
      end else if (accept) begin
         if (state_reg == IDLE) begin
            vec_count_reg <= 16'd1;
         end else if (vec_count_reg != 16'hFFFF) begin
            vec_count_reg <= vec_count_reg + 16'd1;
         end
      end
   end

   assign vec_count = vec_count_reg;
`endif

   assign bus.in_ready = ready_int;
   assign bus.left_out = left_vec;
   assign bus.top_out  = top_vec;
   assign bus.busy     = busy_int;
   assign bus.done     = done_int;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed table-driven bench for the skew feeder at N=4, DATA_WIDTH=8, plus a hand-written long job.
module tb_systolic_skew_feeder;
   localparam int DW = 8;
   localparam int N  = 4;

   typedef struct {
      logic        rst;
      logic        valid;
      logic        last;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_left;
      logic [31:0] exp_top;
      logic        exp_ready;
      logic        exp_busy;
      logic        exp_done;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t rows[$];

   systolic_skew_feeder_if #(.DATA_WIDTH(DW), .ARRAY_SIZE(N)) bus ();

`ifdef SKEW_FEEDER_STATS_EN
   logic [15:0] vec_count;
`endif

   systolic_skew_feeder #(.DATA_WIDTH(DW), .ARRAY_SIZE(N)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef SKEW_FEEDER_STATS_EN
      ,
      .vec_count(vec_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic row(input logic r, input logic v, input logic l,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] el, input logic [31:0] et,
                      input logic rdy, input logic bsy, input logic dn);
      vec_t x;
      x.rst = r; x.valid = v; x.last = l; x.a = a; x.b = b;
      x.exp_left = el; x.exp_top = et;
      x.exp_ready = rdy; x.exp_busy = bsy; x.exp_done = dn;
      rows.push_back(x);
   endtask

   // Single vector with last=1; a write attempted during FLUSH must be ignored.
   task automatic add_single();
      row(0, 1, 1, 32'h04030201, 32'h08070605, 32'h0, 32'h0, 1, 0, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h00000001, 32'h00000005, 0, 1, 0);
      row(0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000200, 32'h00000600, 0, 1, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h00030000, 32'h00070000, 0, 1, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h04000000, 32'h08000000, 0, 1, 0);
      for (int i = 0; i < 3; i++) row(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1);
      row(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
   endtask

   initial begin
      int cyc;
      bus.in_a = '0; bus.in_b = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;

      // Reset held through two edges, then release
      row(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 0);

      add_single();

      // Back-to-back job of four vectors
      row(0, 1, 0, 32'h0A0A0A0A, 32'h20202020, 32'h0, 32'h0, 1, 0, 0);
      row(0, 1, 0, 32'h0B0B0B0B, 32'h21212121, 32'h0000000A, 32'h00000020, 1, 1, 0);
      row(0, 1, 0, 32'h0C0C0C0C, 32'h22222222, 32'h00000A0B, 32'h00002021, 1, 1, 0);
      row(0, 1, 1, 32'h0D0D0D0D, 32'h23232323, 32'h000A0B0C, 32'h00202122, 1, 1, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h0A0B0C0D, 32'h20212223, 0, 1, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h0B0C0D00, 32'h21222300, 0, 1, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h0C0D0000, 32'h22230000, 0, 1, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h0D000000, 32'h23000000, 0, 1, 0);
      for (int i = 0; i < 3; i++) row(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1);
      row(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 0);

      // One-cycle bubble between two vectors
      row(0, 1, 0, 32'h11111111, 32'h33333333, 32'h0, 32'h0, 1, 0, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h00000011, 32'h00000033, 1, 1, 0);
      row(0, 1, 1, 32'h22222222, 32'h44444444, 32'h00001100, 32'h00003300, 1, 1, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h00110022, 32'h00330044, 0, 1, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h11002200, 32'h33004400, 0, 1, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h00220000, 32'h00440000, 0, 1, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h22000000, 32'h44000000, 0, 1, 0);
      for (int i = 0; i < 3; i++) row(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1);
      row(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 0);

      // Reset two cycles into FLUSH: job aborted, no done, then a clean job
      row(0, 1, 1, 32'h04030201, 32'h08070605, 32'h0, 32'h0, 1, 0, 0);
      row(0, 0, 0, 32'h0, 32'h0, 32'h00000001, 32'h00000005, 0, 1, 0);
      row(1, 1, 0, 32'h55555555, 32'h55555555, 32'h00000200, 32'h00000600, 0, 1, 0);
      for (int i = 0; i < 8; i++) row(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
      add_single();

      foreach (rows[i]) begin
         @(negedge clk);
         rst          = rows[i].rst;
         bus.in_valid = rows[i].valid;
         bus.in_last  = rows[i].last;
         bus.in_a     = rows[i].a;
         bus.in_b     = rows[i].b;
         #1;
         $display("row %0d: rst=%b v=%b l=%b left=%h top=%h rdy=%b busy=%b done=%b",
                  i, rst, bus.in_valid, bus.in_last, bus.left_out, bus.top_out,
                  bus.in_ready, bus.busy, bus.done);
         check($sformatf("row%0d left_out", i), bus.left_out, rows[i].exp_left);
         check($sformatf("row%0d top_out", i), bus.top_out, rows[i].exp_top);
         check($sformatf("row%0d in_ready", i), {31'b0, bus.in_ready}, {31'b0, rows[i].exp_ready});
         check($sformatf("row%0d busy", i), {31'b0, bus.busy}, {31'b0, rows[i].exp_busy});
         check($sformatf("row%0d done", i), {31'b0, bus.done}, {31'b0, rows[i].exp_done});
      end

      // Five-vector job; in_valid kept high through FLUSH must not be accepted
      for (int v = 0; v < 5; v++) begin
         @(negedge clk);
         rst          = 1'b0;
         bus.in_valid = 1'b1;
         bus.in_last  = (v == 4);
         bus.in_a     = {4{8'(8'h60 + v)}};
         bus.in_b     = {4{8'(8'h70 + v)}};
         $display("job5 vector %0d driven", v);
      end
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         bus.in_last = 1'b0;
         bus.in_a    = 32'hDEADBEEF;
         bus.in_b    = 32'hDEADBEEF;
         #1;
      end while (!bus.done && cyc < 30);
      $display("job5: done after %0d cycles", cyc);
      check("job5 done latency", 32'(cyc), 32'd8);
`ifdef SKEW_FEEDER_STATS_EN
      check("job5 vec_count at done", {16'b0, vec_count}, 32'd5);
`endif
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      check("job5 idle ready", {31'b0, bus.in_ready}, 32'd1);
      check("job5 idle busy", {31'b0, bus.busy}, 32'd0);
      check("job5 idle left_out", bus.left_out, 32'h0);
`ifdef SKEW_FEEDER_STATS_EN
      check("job5 vec_count held", {16'b0, vec_count}, 32'd5);
`endif
      @(negedge clk);
      #1;
      check("job5 no new job", {31'b0, bus.busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, element width in bits.
REQ-002 Parameter ARRAY_SIZE, default 16, array dimension N (N >= 2).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_a  input  N*DATA_WIDTH  A-matrix column vector; lane i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 in_b  input  N*DATA_WIDTH  B-matrix row vector; lane j at [j*DATA_WIDTH +: DATA_WIDTH].
REQ-007 in_valid  input  1  in_a/in_b/in_last valid.
REQ-008 in_last  input  1  marks the final vector of a job.
REQ-009 in_ready  output  1  feeder accepts a vector this cycle.
REQ-010 left_out  output  N*DATA_WIDTH  skewed row stream to array left_in.
REQ-011 top_out  output  N*DATA_WIDTH  skewed column stream to array top_in.
REQ-012 busy  output  1  high in STREAM and FLUSH.
REQ-013 done  output  1  one-cycle pulse: array results complete.

Function
REQ-014 Accept (handshake) occurs when in_valid && in_ready at a rising edge; in_valid SHALL be able to deassert at any time without penalty.
REQ-015 States: IDLE, STREAM, FLUSH, DONE; in_ready SHALL be 1 in IDLE and STREAM, 0 in FLUSH and DONE.
REQ-016 IDLE -> STREAM on accept with in_last=0; IDLE -> FLUSH on accept with in_last=1.
REQ-017 STREAM -> FLUSH on accept with in_last=1; otherwise remain in STREAM.
REQ-018 FLUSH lasts exactly 2*N-1 cycles (skew N-1 + propagation N-1 + PE register 1), counted by a down-counter, then -> DONE.
REQ-019 DONE lasts one cycle with done=1, then -> IDLE; done SHALL be 0 in all other states.
REQ-020 Each cycle the feeder SHALL form a slot vector: the accepted vector if accept, else all-zero (bubble); bubbles apply to A and B together to preserve alignment.
REQ-021 Lane k of left_out at cycle t SHALL equal lane k of in_a from the slot at cycle t-1-k; same rule for top_out with in_b (lane 0 latency 1 cycle, lane k latency 1+k).
REQ-022 Skew storage SHALL be a per-lane shift register of depth k+1 (triangular); outputs registered; no combinational path from inputs to outputs.
REQ-023 Slots before the first accept after reset, and all slots in FLUSH/DONE/IDLE, SHALL be zero, so stale data never reaches the array.
REQ-024 Data SHALL pass unmodified (no sign/width change); zero-fill is literal all-zero bits.
REQ-025 busy SHALL equal (state==STREAM || state==FLUSH).

Reset
REQ-026 rst=1 at a rising edge SHALL force state IDLE, all skew registers 0, flush counter 0, left_out=0, top_out=0, busy=0, done=0, in_ready=1 (after release).
REQ-027 rst asserted mid-STREAM or mid-FLUSH SHALL abort the job with no done pulse; in-flight data discarded.
REQ-028 While rst=1, in_ready SHALL be 0 and no accept occurs.

Configuration
REQ-029 Macro SKEW_FEEDER_STATS_EN: when defined, adds output vec_count (16 bits) counting accepts in the current job, cleared on rst and on IDLE-start accept (set to 1), saturating at 16'hFFFF, held through FLUSH/DONE.
REQ-030 Without SKEW_FEEDER_STATS_EN, vec_count port and counter SHALL not exist; all other behaviour identical.

Verification (N=4, DATA_WIDTH=8)
REQ-031 Reset: assert rst 2 cycles -> left_out=0, top_out=0, busy=0, done=0, in_ready=1 first cycle after release.
REQ-032 Single vector in_a=lanes{1,2,3,4}, in_last=1 at t0 -> left_out lane k=k+1 exactly at t0+1+k, zero elsewhere; done pulse at t0+1+7 (7 FLUSH cycles); in_ready 0 during FLUSH.
REQ-033 Back-to-back 4 vectors (A lane0 = 10,11,12,13) -> left_out lane0 10..13 on consecutive cycles, lane3 same sequence 3 cycles later; done once after 7 FLUSH cycles.
REQ-034 Bubble: vectors 1 and 2 separated by one in_valid=0 cycle -> a zero slot appears between them on every lane of both outputs, same relative offset.
REQ-035 rst asserted 2 cycles into FLUSH -> no done pulse, outputs 0, next job behaves as REQ-032.
REQ-036 With SKEW_FEEDER_STATS_EN: 5-vector job -> vec_count=5 at done; in_valid during FLUSH not counted.
